// File: rtl/mdu_pkg.sv
// Shared encodings and default parameters for the multiply/divide unit.
// Op codes, FSM states and default latencies are defined here once.
package mdu_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DIV_LAT = 10;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MADD  = 4'd5,
        MDU_MADDU = 4'd6,
        MDU_MSUB  = 4'd7,
        MDU_MSUBU = 4'd8,
        MDU_MTHI  = 4'd9,
        MDU_MTLO  = 4'd10,
        MDU_MFHI  = 4'd11,
        MDU_MFLO  = 4'd12
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    function automatic logic is_mul_op(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD) ||
               (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
    endfunction

    function automatic logic is_div_op(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: product, multiply-accumulate and division results
// for the latched operands, with a write-enable that is low on divide by zero.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  mdu_op_e            op_i,
    input  logic [2*WIDTH-1:0] hilo_i,
    output logic [2*WIDTH-1:0] hilo_o,
    output logic               we_o
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    logic             sgn_s;
    logic [W2-1:0]    a_ext_s;
    logic [W2-1:0]    b_ext_s;
    logic [W2-1:0]    prod_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;

    // Operand conditioning, product and sign-magnitude division.
    always_comb begin
        sgn_s   = (op_i == MDU_MULT) || (op_i == MDU_MADD) ||
                  (op_i == MDU_MSUB) || (op_i == MDU_DIV);
        a_ext_s = sgn_s ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
        b_ext_s = sgn_s ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
        // Low 2*WIDTH bits of the sign-extended product equal the exact product.
        prod_s  = a_ext_s * b_ext_s;

        a_neg_s = sgn_s & a_i[WIDTH-1];
        b_neg_s = sgn_s & b_i[WIDTH-1];
        a_mag_s = a_neg_s ? -a_i : a_i;
        b_mag_s = b_neg_s ? -b_i : b_i;
        if (b_mag_s != ZERO_W) begin
            quo_s = a_mag_s / b_mag_s;
            rem_s = a_mag_s % b_mag_s;
        end else begin
            quo_s = ZERO_W;
            rem_s = ZERO_W;
        end
        // Most-negative / -1 wraps back to most-negative with zero remainder.
        if (a_neg_s ^ b_neg_s) begin
            quo_s = -quo_s;
        end else begin
            quo_s = quo_s;
        end
        if (a_neg_s) begin
            rem_s = -rem_s;
        end else begin
            rem_s = rem_s;
        end
    end

    // Result selection per operation.
    always_comb begin
        hilo_o = hilo_i;
        we_o   = 1'b0;
        case (op_i)
            MDU_MULT, MDU_MULTU: begin
                hilo_o = prod_s;
                we_o   = 1'b1;
            end
            MDU_MADD, MDU_MADDU: begin
                hilo_o = hilo_i + prod_s;
                we_o   = 1'b1;
            end
            MDU_MSUB, MDU_MSUBU: begin
                hilo_o = hilo_i - prod_s;
                we_o   = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
                hilo_o = {rem_s, quo_s};
                we_o   = (b_mag_s != ZERO_W);
            end
            default: begin
                hilo_o = hilo_i;
                we_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_param.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Launch latches operands; a down-counter times the op and commits HI/LO.
module mdu_param
    import mdu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Req,
    input  logic             Start,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_LAT - 1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mdu_op_e          op_q, op_d;
    logic [WIDTH-1:0] d1_q, d1_d;
    logic [WIDTH-1:0] d2_q, d2_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;

    mdu_op_e            op_in_s;
    logic               accept_s;
    logic [2*WIDTH-1:0] hilo_nxt_s;
    logic               hilo_we_s;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .a_i    (d1_q),
        .b_i    (d2_q),
        .op_i   (op_q),
        .hilo_i ({hi_q, lo_q}),
        .hilo_o (hilo_nxt_s),
        .we_o   (hilo_we_s)
    );

    // Next-state logic: launch, countdown, commit and HI/LO moves.
    always_comb begin
        op_in_s  = mdu_op_e'(MDUOp);
        accept_s = Start & ~Req & ~busy_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && is_mul_op(op_in_s)) begin
                    state_d = ST_MUL;
                    cnt_d   = CNT_MUL;
                    busy_d  = 1'b1;
                    op_d    = op_in_s;
                    d1_d    = D1;
                    d2_d    = D2;
                end else if (accept_s && is_div_op(op_in_s)) begin
                    state_d = ST_DIV;
                    cnt_d   = CNT_DIV;
                    busy_d  = 1'b1;
                    op_d    = op_in_s;
                    d1_d    = D1;
                    d2_d    = D2;
                end else if (accept_s && (op_in_s == MDU_MTHI)) begin
                    hi_d = D1;
                end else if (accept_s && (op_in_s == MDU_MTLO)) begin
                    lo_d = D1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (hilo_we_s) begin
                        {hi_d, lo_d} = hilo_nxt_s;
                    end else begin
                        hi_d = hi_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            op_q    <= MDU_NONE;
            d1_q    <= ZERO_W;
            d2_q    <= ZERO_W;
            hi_q    <= ZERO_W;
            lo_q    <= ZERO_W;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_param.sv
// Directed self-checking bench for mdu_param (WIDTH 32, MUL_LAT 5, DIV_LAT 10).
module tb_mdu_param;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        Req;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] D1;
    logic [31:0] D2;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int errors;

    mdu_param #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Req   (Req),
        .Start (Start),
        .MDUOp (MDUOp),
        .D1    (D1),
        .D2    (D2),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op for a single cycle; the launch edge is the next posedge.
    task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start = 1'b1;
        MDUOp = op;
        D1    = a;
        D2    = b;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = MDU_NONE;
    endtask

    // Count negedges with Busy high, bounded.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (Busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        Req = 1'b0; Start = 1'b0; MDUOp = MDU_NONE; D1 = 32'd0; D2 = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: Busy=%b HI=%h LO=%h, required 0/0/0", Busy, HI, LO);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult;
        int cyc;
        issue(MDU_MULT, 32'hFFFFFFFE, 32'd3);
        wait_idle(cyc);
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL mult_busy: busy cycles=%0d, required 5", cyc);
        end
        checks++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL mult_result: HI=%h LO=%h, required ffffffff/fffffffa", HI, LO);
        end
        issue(MDU_MULTU, 32'hFFFFFFFE, 32'd3);
        wait_idle(cyc);
        checks++;
        if (cyc !== 5 || HI !== 32'h00000002 || LO !== 32'hFFFFFFFA) begin
            errors++;
            $display("FAIL multu_result: cyc=%0d HI=%h LO=%h, required 5 00000002/fffffffa", cyc, HI, LO);
        end
    endtask

    task automatic test_div;
        int cyc;
        issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle(cyc);
        checks++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL div_busy: busy cycles=%0d, required 10", cyc);
        end
        checks++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL div_result: HI=%h LO=%h, required ffffffff/fffffffd", HI, LO);
        end
        issue(MDU_DIV, 32'd55, 32'd0);
        wait_idle(cyc);
        checks++;
        if (cyc !== 10 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL div_zero: cyc=%0d HI=%h LO=%h, required 10 ffffffff/fffffffd", cyc, HI, LO);
        end
        issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(cyc);
        checks++;
        if (HI !== 32'h00000000 || LO !== 32'h80000000) begin
            errors++;
            $display("FAIL div_overflow: HI=%h LO=%h, required 00000000/80000000", HI, LO);
        end
        issue(MDU_DIVU, 32'hFFFFFFF9, 32'd2);
        wait_idle(cyc);
        checks++;
        if (HI !== 32'h00000001 || LO !== 32'h7FFFFFFC) begin
            errors++;
            $display("FAIL divu_result: HI=%h LO=%h, required 00000001/7ffffffc", HI, LO);
        end
    endtask

    task automatic test_mac;
        int cyc;
        issue(MDU_MTHI, 32'd5, 32'd0);
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd5) begin
            errors++;
            $display("FAIL mthi: Busy=%b HI=%h, required 0/00000005", Busy, HI);
        end
        issue(MDU_MTLO, 32'd7, 32'd0);
        checks++;
        if (Busy !== 1'b0 || LO !== 32'd7 || HI !== 32'd5) begin
            errors++;
            $display("FAIL mtlo: Busy=%b HI=%h LO=%h, required 0/00000005/00000007", Busy, HI, LO);
        end
        issue(MDU_MADD, 32'd2, 32'd3);
        wait_idle(cyc);
        checks++;
        if (cyc !== 5 || HI !== 32'd5 || LO !== 32'd13) begin
            errors++;
            $display("FAIL madd: cyc=%0d HI=%h LO=%h, required 5 00000005/0000000d", cyc, HI, LO);
        end
        issue(MDU_MSUBU, 32'd14, 32'd1);
        wait_idle(cyc);
        checks++;
        if (HI !== 32'd4 || LO !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL msubu: HI=%h LO=%h, required 00000004/ffffffff", HI, LO);
        end
    endtask

    task automatic test_req;
        int cyc;
        Req = 1'b1;
        issue(MDU_MULT, 32'd9, 32'd9);
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd4 || LO !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL req_mult: Busy=%b HI=%h LO=%h, required 0/00000004/ffffffff", Busy, HI, LO);
        end
        issue(MDU_MTHI, 32'd99, 32'd0);
        Req = 1'b0;
        checks++;
        if (HI !== 32'd4) begin
            errors++;
            $display("FAIL req_mthi: HI=%h, required 00000004", HI);
        end
        issue(MDU_DIVU, 32'd100, 32'd7);
        cyc = 0;
        while (Busy && cyc < 100) begin
            cyc++;
            Req = (cyc == 3);
            @(negedge clk);
        end
        Req = 1'b0;
        checks++;
        if (cyc !== 10 || HI !== 32'd2 || LO !== 32'd14) begin
            errors++;
            $display("FAIL req_mid_div: cyc=%0d HI=%h LO=%h, required 10 00000002/0000000e", cyc, HI, LO);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        issue(MDU_MULT, 32'd7, 32'd6);
        cyc = 0;
        while (Busy && cyc < 100) begin
            cyc++;
            Start = (cyc == 2);
            MDUOp = (cyc == 2) ? MDU_MULTU : MDU_NONE;
            D1    = 32'd100;
            D2    = 32'd100;
            @(negedge clk);
        end
        Start = 1'b0;
        MDUOp = MDU_NONE;
        checks++;
        if (cyc !== 5 || HI !== 32'd0 || LO !== 32'd42) begin
            errors++;
            $display("FAIL start_while_busy: cyc=%0d HI=%h LO=%h, required 5 00000000/0000002a", cyc, HI, LO);
        end
        issue(MDU_MADDU, 32'd10, 32'd10);
        wait_idle(cyc);
        checks++;
        if (cyc !== 5 || HI !== 32'd0 || LO !== 32'd142) begin
            errors++;
            $display("FAIL back_to_back: cyc=%0d HI=%h LO=%h, required 5 00000000/0000008e", cyc, HI, LO);
        end
    endtask

    task automatic test_reset_mid;
        issue(MDU_MULT, 32'd3, 32'd4);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_async: Busy=%b HI=%h LO=%h, required 0/0/0", Busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset_no_commit: Busy=%b HI=%h LO=%h, required 0/0/0", Busy, HI, LO);
        end
        issue(MDU_MTLO, 32'h1234, 32'd0);
        checks++;
        if (LO !== 32'h1234 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: Busy=%b LO=%h, required 0/00001234", Busy, LO);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_div();
        test_mac();
        test_req();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
